dpram_fifo_ctrl: RTL
====================

// Module: dpram_fifo_ctrl
// PURPOSE
//  Synchronous FIFO controller that sits directly upstream of the asynchronous dual-port RAM.
//  Converts a valid/ready write stream into RAM wr_en/wr_addr/wr_data accesses.
//  Drains the RAM through rd_en/rd_addr into a registered valid/ready output stage.
//  The RAM performs at most one access per cycle (write-only or read-only), so this block
//  arbitrates between the two and never asserts ram_wr_en and ram_rd_en together.
// PARAMETERS
//  ADDR_SIZE      4   RAM address width; DEPTH = 2**ADDR_SIZE RAM entries
//  DATA_SIZE      8   data word width
//  AFULL_THRESH  14   almost_full asserts when count >= AFULL_THRESH
//  AEMPTY_THRESH  1   almost_empty asserts when count <= AEMPTY_THRESH
// PORTS
//  clk           in   1            rising-edge clock
//  reset         in   1            reset, synchronous, active-high
//  in_valid      in   1            upstream word valid
//  in_ready      out  1            upstream word accepted when in_valid&in_ready
//  in_data       in   DATA_SIZE    upstream word
//  out_valid     out  1            out_data holds a valid word
//  out_ready     in   1            downstream consumes when out_valid&out_ready
//  out_data      out  DATA_SIZE    registered output word
//  ram_wr_en     out  1            RAM write strobe (comb)
//  ram_wr_addr   out  ADDR_SIZE    = wr_ptr
//  ram_wr_data   out  DATA_SIZE    = in_data
//  ram_rd_en     out  1            RAM read strobe (comb)
//  ram_rd_addr   out  ADDR_SIZE    = rd_ptr
//  ram_rd_data   in   DATA_SIZE    RAM read data; valid in the same cycle as ram_rd_en
//  count         out  ADDR_SIZE+1  total occupancy = mem_count + out_valid (0..DEPTH+1)
//  full / empty  out  1 each       mem_count==DEPTH / count==0
//  almost_full   out  1            count >= AFULL_THRESH
//  almost_empty  out  1            count <= AEMPTY_THRESH
// BEHAVIOUR
//  State: wr_ptr, rd_ptr (ADDR_SIZE, wrap modulo DEPTH), mem_count (0..DEPTH), out_valid,
//   out_data, prio (0=WRITE, 1=READ).
//  Reset state: ptrs=0, mem_count=0, out_valid=0, out_data=0, prio=WRITE.
//   in_ready, ram_wr_en and ram_rd_en are forced 0 while reset=1.
//   RAM contents are never relied on after reset.
//  wr_req = in_valid & (mem_count!=DEPTH).
//  rd_req = (mem_count!=0) & (!out_valid | out_ready).
//  Grant: a lone request wins. If both request, prio decides, and prio flips after every
//   contended cycle (strict alternation).
//  in_ready  = !reset & (mem_count!=DEPTH) & (!rd_req | prio==WRITE).
//   in_ready never depends on in_valid.
//  ram_wr_en = in_valid & in_ready.
//  ram_rd_en = !reset & rd_req & (!wr_req | prio==READ).
//  Invariant: ram_wr_en & ram_rd_en == 0 in every cycle.
//  Write grant: wr_ptr+1 and mem_count+1 at the edge.
//  Read grant: out_data<=ram_rd_data, out_valid<=1, rd_ptr+1, mem_count-1 at the edge.
//  Pop without read grant (out_valid&out_ready, no ram_rd_en): out_valid<=0.
//  Latency: word accepted at edge E appears as out_valid=1 after edge E+1 (empty FIFO,
//   out_ready=1). Sustained throughput under contention is one word per 2 cycles.
//  Boundaries:
//   - full: in_ready=0. Up to DEPTH+1 words are held (DEPTH in RAM plus 1 in out stage).
//   - empty RAM: no ram_rd_en.
//   - Pointers wrap DEPTH-1 -> 0 with no gap.
//   - Reset mid-operation discards all words on the next edge.
//  FIFO order is strictly preserved. Words are never dropped or duplicated.
// TESTING
//  1 reset; out_ready=0; push 0xA1,0xA2,0xA3 -> all accepted, out_data=0xA1, out_valid=1, count=3.
//  2 out_ready=0; push 0x00..0x10 (17 words) -> count=17, full=1, in_ready=0;
//    almost_full first high at count=14; 18th word is held off.
//  3 in_valid=1 and out_ready=1 continuously, 32 words -> ram_wr_en&ram_rd_en never 1;
//    grants alternate once both request; output order intact.
//  4 stream 0x00..0x27 (40 words) with random in_valid/out_ready -> pointers wrap twice;
//    output exactly 0x00..0x27 in order.
//  5 count=5, assert reset for 1 cycle -> next cycle count=0, empty=1, out_valid=0,
//    ptrs=0; in_ready=0 during reset.
//  6 empty FIFO, out_ready=1 for 10 cycles -> ram_rd_en=0, out_valid=0, almost_empty=1.

Source files
------------

// File: rtl/dpram_fifo_ctrl.sv
// dpram_fifo_ctrl
// FIFO controller in front of a single-access-per-cycle dual-port RAM.
// The upstream valid/ready stream is written into the RAM. The RAM is drained
// into one registered output word. When a write and a read both want the RAM
// in the same cycle, they take turns on it in strict alternation.
module dpram_fifo_ctrl #(
  parameter int ADDR_SIZE     = 4,
  parameter int DATA_SIZE     = 8,
  parameter int AFULL_THRESH  = 14,
  parameter int AEMPTY_THRESH = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DATA_SIZE-1:0] in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DATA_SIZE-1:0] out_data,
  output logic                 ram_wr_en,
  output logic [ADDR_SIZE-1:0] ram_wr_addr,
  output logic [DATA_SIZE-1:0] ram_wr_data,
  output logic                 ram_rd_en,
  output logic [ADDR_SIZE-1:0] ram_rd_addr,
  input  logic [DATA_SIZE-1:0] ram_rd_data,
  output logic [ADDR_SIZE:0]   count,
  output logic                 full,
  output logic                 empty,
  output logic                 almost_full,
  output logic                 almost_empty
);

  localparam int unsigned DEPTH = 1 << ADDR_SIZE;

  // Occupancy counters are one bit wider than the pointers so that DEPTH
  // (RAM full) and DEPTH+1 (RAM full plus output word) are representable.
  localparam logic [ADDR_SIZE:0]   MEM_FULL    = DEPTH[ADDR_SIZE:0];
  localparam logic [ADDR_SIZE:0]   CNT_ZERO    = '0;
  localparam logic [ADDR_SIZE:0]   CNT_ONE     = {{ADDR_SIZE{1'b0}}, 1'b1};
  localparam logic [ADDR_SIZE-1:0] PTR_ONE     = {{(ADDR_SIZE-1){1'b0}}, 1'b1};
  localparam logic [ADDR_SIZE:0]   AFULL_LVL   = AFULL_THRESH[ADDR_SIZE:0];
  localparam logic [ADDR_SIZE:0]   AEMPTY_LVL  = AEMPTY_THRESH[ADDR_SIZE:0];

  // Which side owns the RAM on the next contended cycle.
  typedef enum logic {
    PRIO_WRITE = 1'b0,
    PRIO_READ  = 1'b1
  } prio_e;

  logic [ADDR_SIZE-1:0] wr_ptr_q,    wr_ptr_d;
  logic [ADDR_SIZE-1:0] rd_ptr_q,    rd_ptr_d;
  logic [ADDR_SIZE:0]   mem_count_q, mem_count_d;
  logic                 out_valid_q, out_valid_d;
  logic [DATA_SIZE-1:0] out_data_q,  out_data_d;
  prio_e                prio_q,      prio_d;

  logic mem_full;
  logic mem_empty;
  logic wr_req;
  logic rd_req;
  logic contended;
  logic wr_gnt;
  logic rd_gnt;
  logic pop;

  // Request, grant and handshake decode; in_ready is kept independent of in_valid.
  always_comb begin
    mem_full  = (mem_count_q == MEM_FULL);
    mem_empty = (mem_count_q == CNT_ZERO);
    wr_req    = in_valid & ~mem_full;
    rd_req    = ~mem_empty & (~out_valid_q | out_ready);
    contended = wr_req & rd_req;
    in_ready  = ~reset & ~mem_full & (~rd_req | (prio_q == PRIO_WRITE));
    wr_gnt    = in_valid & in_ready;
    rd_gnt    = ~reset & rd_req & (~wr_req | (prio_q == PRIO_READ));
    pop       = out_valid_q & out_ready;
  end

  // Next-state computation for pointers, occupancy, output stage and priority.
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    mem_count_d = mem_count_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    prio_d      = prio_q;

    if (reset) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      mem_count_d = '0;
      out_valid_d = 1'b0;
      out_data_d  = '0;
      prio_d      = PRIO_WRITE;
    end else begin
      if (wr_gnt) begin
        wr_ptr_d = wr_ptr_q + PTR_ONE;
      end

      // A read refills the output word; a pop with no refill empties it.
      if (rd_gnt) begin
        out_data_d  = ram_rd_data;
        out_valid_d = 1'b1;
        rd_ptr_d    = rd_ptr_q + PTR_ONE;
      end else if (pop) begin
        out_valid_d = 1'b0;
      end

      // Write and read grants are exclusive, so at most one adjustment applies.
      if (wr_gnt) begin
        mem_count_d = mem_count_q + CNT_ONE;
      end else if (rd_gnt) begin
        mem_count_d = mem_count_q - CNT_ONE;
      end

      if (contended) begin
        prio_d = (prio_q == PRIO_WRITE) ? PRIO_READ : PRIO_WRITE;
      end
    end
  end

  // State registers; reset is folded into the next-state logic.
  always_ff @(posedge clk) begin
    wr_ptr_q    <= wr_ptr_d;
    rd_ptr_q    <= rd_ptr_d;
    mem_count_q <= mem_count_d;
    out_valid_q <= out_valid_d;
    out_data_q  <= out_data_d;
    prio_q      <= prio_d;
  end

  // RAM side and status outputs.
  always_comb begin
    ram_wr_en    = wr_gnt;
    ram_wr_addr  = wr_ptr_q;
    ram_wr_data  = in_data;
    ram_rd_en    = rd_gnt;
    ram_rd_addr  = rd_ptr_q;
    out_valid    = out_valid_q;
    out_data     = out_data_q;
    count        = mem_count_q + {{ADDR_SIZE{1'b0}}, out_valid_q};
    full         = mem_full;
    empty        = (count == CNT_ZERO);
    almost_full  = (count >= AFULL_LVL);
    almost_empty = (count <= AEMPTY_LVL);
  end

endmodule
